// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared definitions for the PLL reset sequencer and its
// downstream reset consumers.
//   - seq_state_e : 2-bit sequencer state encoding
//   - DEF_*       : default sequencing parameters (50 MHz reference)
//   - max3        : helper used to size the shared sequencing counter
package clk_rst_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_PLL_RST_CYC     = 5;      // 100 ns at 50 MHz
    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_RELOCK_TIMEOUT  = 65536;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchronizer for a single level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input level
//   q     : synchronized level, STAGES edges behind d
// STAGES must be at least 2.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer in front of the board PLL.
// Pulses the PLL reset, qualifies the lock indication for LOCK_STABLE_CYC
// cycles, then releases the system reset. Re-runs the sequence on lock loss,
// lock timeout or a software request.
//   clk        : board reference clock (also the PLL refclk)
//   rst_n      : asynchronous active-low reset for the whole block
//   pll_locked : PLL lock indication, asynchronous to clk
//   sw_rst     : single-cycle restart request, synchronous to clk
//   pll_rst    : active-high PLL reset (registered)
//   sys_rst_n  : active-low system reset for downstream domains (registered)
//   seq_state  : current sequencer state
//   lock_err   : sticky lock-timeout flag, cleared only by rst_n
//   relock_cnt : saturating count of lock losses seen in RUN
module pll_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int PLL_RST_CYC     = DEF_PLL_RST_CYC,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int RELOCK_TIMEOUT  = DEF_RELOCK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_rst,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [1:0] seq_state,
    output logic       lock_err,
    output logic [7:0] relock_cnt
);

    localparam int CNT_MAX = max3(PLL_RST_CYC, LOCK_STABLE_CYC, RELOCK_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RELOCK_TIMEOUT - 1);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_s;
    logic             timeout_hit;
    logic             lock_loss;
    logic             pll_rst_nxt, sys_rst_n_nxt;

    // Only consumer of pll_locked.
    sync_bit #(.STAGES(2)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // State register and shared counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PLL_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; sw_rst overrides everything at the end.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        timeout_hit = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle wins over the re-pulse.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_PLL_RST;
                    cnt_nxt     = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;   // counter idle in RUN
                if (!lock_s) state_nxt = ST_PLL_RST;
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
        if (sw_rst) begin
            state_nxt   = ST_PLL_RST;
            cnt_nxt     = '0;
            timeout_hit = 1'b0;
        end
    end

    // A lock loss in RUN is counted even when sw_rst arrives on the same edge.
    assign lock_loss = (state == ST_RUN) && !lock_s;

    // Output decode from the next state so the outputs move with the state.
    always_comb begin
        pll_rst_nxt   = (state_nxt == ST_PLL_RST);
        sys_rst_n_nxt = (state_nxt == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
        end else begin
            pll_rst   <= pll_rst_nxt;
            sys_rst_n <= sys_rst_n_nxt;
        end
    end

    // Status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_err   <= 1'b0;
            relock_cnt <= '0;
        end else begin
            if (timeout_hit) lock_err <= 1'b1;
            if (lock_loss && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Testbench for pll_rst_seq: randomized lock behaviour scored against a
// timestamp-based reference model; expected outputs are queued per edge and
// compared by an independent monitor on the falling edge.
module tb_pll_rst_seq;

    localparam int PRC = 5;
    localparam int LSC = 16;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_rst = 1'b0;
    logic       pll_rst, sys_rst_n, lock_err;
    logic [1:0] seq_state;
    logic [7:0] relock_cnt;

    typedef struct packed {
        logic       pr;
        logic       sr;
        logic [1:0] st;
        logic       err;
        logic [7:0] rel;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_pr = 1'b1;
    logic mon_sr = 1'b0;
    int   g_edge = 0;

    always #10 clk = ~clk;

    pll_rst_seq #(
        .PLL_RST_CYC     (PRC),
        .LOCK_STABLE_CYC (LSC),
        .RELOCK_TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_rst     (sw_rst),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .seq_state  (seq_state),
        .lock_err   (lock_err),
        .relock_cnt (relock_cnt)
    );

    // Reference model: phase (0 reset pulse, 1 waiting, 2 qualifying, 3 running)
    // plus the edge index at which the phase was entered. Elapsed time in a
    // phase is derived from timestamps; lock history models the 2-edge delay.
    int m_ph, m_t0, m_cyc, m_rel;
    bit m_h0, m_h1, m_err;

    function automatic void model_reset();
        m_ph = 0; m_t0 = m_cyc; m_h0 = 0; m_h1 = 0; m_err = 0; m_rel = 0;
    endfunction

    function automatic void model_step(input bit sw, input bit lk);
        bit lock_s;
        int el, np;
        bit enter;
        lock_s = m_h1;
        m_h1 = m_h0;
        m_h0 = lk;
        el = m_cyc - m_t0;
        np = m_ph;
        enter = 0;
        if (m_ph == 3 && !lock_s && m_rel < 255) m_rel++;
        if (sw) begin
            np = 0; enter = 1;
        end else if (m_ph == 0) begin
            if (el == PRC - 1) begin np = 1; enter = 1; end
        end else if (m_ph == 1) begin
            if (lock_s) begin np = 2; enter = 1; end
            else if (el == TMO - 1) begin np = 0; enter = 1; m_err = 1; end
        end else if (m_ph == 2) begin
            if (!lock_s) begin np = 1; enter = 1; end
            else if (el == LSC - 1) begin np = 3; enter = 1; end
        end else begin
            if (!lock_s) begin np = 0; enter = 1; end
        end
        if (enter) m_t0 = m_cyc + 1;
        m_ph = np;
        m_cyc++;
    endfunction

    function automatic obs_t m_obs();
        obs_t o;
        o.pr  = (m_ph == 0);
        o.sr  = (m_ph == 3);
        o.st  = 2'(m_ph);
        o.err = m_err;
        o.rel = 8'(m_rel);
        return o;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock edge: model the edge with the inputs the DUT sampled, queue
    // the expected outputs, then leave 2 ns for the caller to drive inputs.
    task automatic step();
        @(posedge clk);
        g_edge++;
        if (!rst_n) begin
            m_cyc++;
            model_reset();
        end else begin
            model_step(sw_rst, pll_locked);
        end
        exp_q.push_back(m_obs());
        #2;
    endtask

    // Monitor
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            mon_pr = pll_rst;
            mon_sr = sys_rst_n;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pll_rst",    32'(pll_rst),    32'(e.pr));
                check("sys_rst_n",  32'(sys_rst_n),  32'(e.sr));
                check("seq_state",  32'(seq_state),  32'(e.st));
                check("lock_err",   32'(lock_err),   32'(e.err));
                check("relock_cnt", 32'(relock_cnt), 32'(e.rel));
                if (pll_rst === 1'b0 && sys_rst_n === 1'b1 && seq_state !== 2'd3)
                    check("released_outside_run", 32'(seq_state), 32'd3);
            end
        end
    end

    // Watchdog
    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pr_edges, lock_edge, rise_edge, hi, d;
        bit found;

        m_cyc = 1;
        model_reset();

        // Power-up: release rst_n at 100 ns, lock 20 edges later
        repeat (5) step();
        #8 rst_n = 1'b1;
        pr_edges = 0;
        repeat (20) begin
            step();
            if (mon_pr) pr_edges++;
        end
        check("pwrup_pll_rst_edges", 32'(pr_edges), 32'(PRC));
        pll_locked = 1'b1;
        lock_edge = g_edge + 1;
        rise_edge = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mon_sr) begin rise_edge = g_edge - 1; break; end
        end
        check("pwrup_lock_to_release", 32'(rise_edge - lock_edge), 32'(LSC + 2));
        repeat (3) step();
        check("pwrup_state_run", 32'(seq_state), 32'd3);

        // Lock timeout: restart with lock held low for three timeout periods
        sw_rst = 1'b1; pll_locked = 1'b0;
        step();
        sw_rst = 1'b0;
        repeat (3 * (PRC + TMO) + 10) step();
        check("timeout_lock_err", 32'(lock_err), 32'd1);

        // Lock glitch in STABLE at cnt=8
        sw_rst = 1'b1; pll_locked = 1'b1;
        step();
        sw_rst = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_ph == 2 && (m_cyc - m_t0) == 8) begin found = 1; break; end
            step();
        end
        check("glitch_reach_cnt8", 32'(found), 32'd1);
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        step();
        check("glitch_state_wait", 32'(seq_state), 32'd1);
        check("glitch_sys_rst_low", 32'(sys_rst_n), 32'd0);
        repeat (LSC + 8) step();
        check("glitch_reaches_run", 32'(seq_state), 32'd3);

        // Lock losses in RUN, with sw_rst mixed in
        for (int i = 0; i < 300; i++) begin
            hi = $urandom_range(30, 34);
            repeat (hi) step();
            if (i % 11 == 5) begin
                sw_rst = 1'b1; step(); sw_rst = 1'b0;
                repeat (30) step();
            end
            pll_locked = 1'b0;
            if (i % 7 == 3) begin
                // sw_rst lands on the edge where lock_s is first seen low
                step(); step();
                sw_rst = 1'b1; step(); sw_rst = 1'b0;
            end else begin
                d = $urandom_range(1, 3);
                repeat (d) step();
            end
            pll_locked = 1'b1;
            if (i == 0) begin
                step(); step();
                check("first_loss_relock", 32'(relock_cnt), 32'd1);
            end
        end
        repeat (40) step();
        check("relock_saturated", 32'(relock_cnt), 32'd255);

        // Async reset mid-STABLE (cnt=10)
        sw_rst = 1'b1; step(); sw_rst = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_ph == 2 && (m_cyc - m_t0) == 10) begin found = 1; break; end
            step();
        end
        check("areset_reach_cnt10", 32'(found), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("areset_pll_rst",    32'(pll_rst),    32'd1);
        check("areset_sys_rst_n",  32'(sys_rst_n),  32'd0);
        check("areset_seq_state",  32'(seq_state),  32'd0);
        check("areset_lock_err",   32'(lock_err),   32'd0);
        check("areset_relock_cnt", 32'(relock_cnt), 32'd0);
        model_reset();
        exp_q[exp_q.size() - 1] = m_obs();
        repeat (3) step();
        #5 rst_n = 1'b1;
        repeat (PRC + LSC + 10) step();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
